// File: rtl/tick_time_counter.sv
// Seconds-tick consumer: synchronises the 1 Hz square wave, detects its rising edge and
// keeps a 24-hour HH:MM:SS time of day with a validated load port and registered BCD view.
module tick_time_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int HOURS_MAX   = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_1hz,
    input  logic        run,
    input  logic        set_valid,
    input  logic [4:0]  set_hh,
    input  logic [5:0]  set_mm,
    input  logic [5:0]  set_ss,
    output logic        set_ack,
    output logic        set_err,
    output logic [4:0]  hh,
    output logic [5:0]  mm,
    output logic [5:0]  ss,
    output logic [23:0] time_bcd,
    output logic        sec_pulse,
    output logic        min_pulse,
    output logic        day_pulse
);

    localparam logic [4:0] HMAX = 5'(HOURS_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   tick;

    logic [4:0]  hh_q, hh_d;
    logic [5:0]  mm_q, mm_d;
    logic [5:0]  ss_q, ss_d;
    logic [23:0] bcd_q, bcd_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        sec_q, sec_d;
    logic        min_q, min_d;
    logic        day_q, day_d;

    logic set_ok;
    logic advance;

    assign sync_d[0] = clk_1hz;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Reset preloads the chain with the live level so a wave already high is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{clk_1hz}};
            prev_q <= clk_1hz;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        if (r >= 6'd60) begin
            r = r - 6'd60;
            t = 4'd6;
        end else if (r >= 6'd50) begin
            r = r - 6'd50;
            t = 4'd5;
        end else if (r >= 6'd40) begin
            r = r - 6'd40;
            t = 4'd4;
        end else if (r >= 6'd30) begin
            r = r - 6'd30;
            t = 4'd3;
        end else if (r >= 6'd20) begin
            r = r - 6'd20;
            t = 4'd2;
        end else if (r >= 6'd10) begin
            r = r - 6'd10;
            t = 4'd1;
        end
        return {t, 4'(r)};
    endfunction

    assign set_ok  = (set_hh <= HMAX) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
    assign advance = tick & run & ~set_valid;

    always_comb begin
        hh_d  = hh_q;
        mm_d  = mm_q;
        ss_d  = ss_q;
        ack_d = 1'b0;
        err_d = 1'b0;
        sec_d = 1'b0;
        min_d = 1'b0;
        day_d = 1'b0;
        bcd_d = {to_bcd({1'b0, hh_q}), to_bcd(mm_q), to_bcd(ss_q)};
        if (set_valid) begin
            if (set_ok) begin
                hh_d  = set_hh;
                mm_d  = set_mm;
                ss_d  = set_ss;
                ack_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (advance) begin
            sec_d = 1'b1;
            if (ss_q != 6'd59) begin
                ss_d = ss_q + 6'd1;
            end else begin
                ss_d  = 6'd0;
                min_d = 1'b1;
                if (mm_q != 6'd59) begin
                    mm_d = mm_q + 6'd1;
                end else begin
                    mm_d = 6'd0;
                    if (hh_q != HMAX) begin
                        hh_d = hh_q + 5'd1;
                    end else begin
                        hh_d  = 5'd0;
                        day_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hh_q  <= 5'd0;
            mm_q  <= 6'd0;
            ss_q  <= 6'd0;
            bcd_q <= 24'h000000;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            sec_q <= 1'b0;
            min_q <= 1'b0;
            day_q <= 1'b0;
        end else begin
            hh_q  <= hh_d;
            mm_q  <= mm_d;
            ss_q  <= ss_d;
            bcd_q <= bcd_d;
            ack_q <= ack_d;
            err_q <= err_d;
            sec_q <= sec_d;
            min_q <= min_d;
            day_q <= day_d;
        end
    end

    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign time_bcd  = bcd_q;
    assign set_ack   = ack_q;
    assign set_err   = err_q;
    assign sec_pulse = sec_q;
    assign min_pulse = min_q;
    assign day_pulse = day_q;

endmodule

// File: tb/tb_tick_time_counter.sv
// Bench for tick_time_counter: directed scenarios with constant expectations, then a random
// run compared every cycle against a seconds-of-day reference model.
module tb_tick_time_counter;

    localparam int SYNC_STAGES = 2;
    localparam int HOURS_MAX   = 23;
    localparam int DAY         = (HOURS_MAX + 1) * 3600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_1hz = 1'b0;
    logic        run = 1'b1;
    logic        set_valid = 1'b0;
    logic [4:0]  set_hh = '0;
    logic [5:0]  set_mm = '0;
    logic [5:0]  set_ss = '0;
    logic        set_ack, set_err;
    logic [4:0]  hh;
    logic [5:0]  mm, ss;
    logic [23:0] time_bcd;
    logic        sec_pulse, min_pulse, day_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    tick_time_counter #(
        .SYNC_STAGES(SYNC_STAGES),
        .HOURS_MAX  (HOURS_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_1hz  (clk_1hz),
        .run      (run),
        .set_valid(set_valid),
        .set_hh   (set_hh),
        .set_mm   (set_mm),
        .set_ss   (set_ss),
        .set_ack  (set_ack),
        .set_err  (set_err),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .time_bcd (time_bcd),
        .sec_pulse(sec_pulse),
        .min_pulse(min_pulse),
        .day_pulse(day_pulse)
    );

    // Reference model: time as seconds since midnight, clk_1hz samples kept as a history.
    int          m_t;
    bit          m_ack, m_err, m_sec, m_min, m_day;
    logic [23:0] m_bcd;
    bit          hist [0:SYNC_STAGES];

    function automatic logic [23:0] bcd_of(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [16:0] hms_of(input int t);
        return hms(t / 3600, (t / 60) % 60, t % 60);
    endfunction

    task automatic model_step();
        bit tick;
        if (!rst_n) begin
            m_t = 0;
            {m_ack, m_err, m_sec, m_min, m_day} = '0;
            m_bcd = 24'h0;
            for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = clk_1hz;
        end else begin
            // A tick lands SYNC_STAGES samples after the first high sample following a low one.
            tick  = hist[SYNC_STAGES-1] && !hist[SYNC_STAGES];
            m_bcd = bcd_of(m_t);
            {m_ack, m_err, m_sec, m_min, m_day} = '0;
            if (set_valid) begin
                if (set_hh <= HOURS_MAX && set_mm <= 59 && set_ss <= 59) begin
                    m_t   = int'(set_hh) * 3600 + int'(set_mm) * 60 + int'(set_ss);
                    m_ack = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end else if (tick && run) begin
                m_t   = (m_t + 1) % DAY;
                m_sec = 1'b1;
                m_min = (m_t % 60 == 0);
                m_day = (m_t == 0);
            end
            for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = clk_1hz;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tick();
        clk_1hz = 1'b1;
        step();
        clk_1hz = 1'b0;
        step();
        step();
    endtask

    task automatic load(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hh = 5'(h);
        set_mm = 6'(m);
        set_ss = 6'(s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clk_1hz = 1'b1;
        step();
        step();
        n_assert++;
        if ({hh, mm, ss, time_bcd} !== {17'd0, 24'h0}) begin
            n_fail++;
            $display("FAIL reset_time: got %h/%h expected 0/000000", {hh, mm, ss}, time_bcd);
        end
        n_assert++;
        if ({set_ack, set_err, sec_pulse, min_pulse, day_pulse} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 00000",
                     {set_ack, set_err, sec_pulse, min_pulse, day_pulse});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_assert++;
            if ({ss, sec_pulse} !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_high_hold cycle %0d: got ss=%0d sec=%b expected ss=0 sec=0",
                         i, ss, sec_pulse);
            end
        end
    endtask

    task automatic test_first_tick();
        clk_1hz = 1'b0;
        repeat (3) step();
        clk_1hz = 1'b1;
        step();
        clk_1hz = 1'b0;
        n_assert++;
        if ({ss, sec_pulse} !== 7'd0) begin
            n_fail++;
            $display("FAIL tick_latency_N: got ss=%0d sec=%b expected ss=0 sec=0", ss, sec_pulse);
        end
        step();
        n_assert++;
        if ({ss, sec_pulse} !== 7'd0) begin
            n_fail++;
            $display("FAIL tick_latency_N1: got ss=%0d sec=%b expected ss=0 sec=0", ss, sec_pulse);
        end
        step();
        n_assert++;
        if ({ss, sec_pulse, time_bcd} !== {6'd1, 1'b1, 24'h000000}) begin
            n_fail++;
            $display("FAIL tick_latency_N2: got ss=%0d sec=%b bcd=%h expected ss=1 sec=1 bcd=000000",
                     ss, sec_pulse, time_bcd);
        end
        step();
        n_assert++;
        if ({sec_pulse, time_bcd} !== {1'b0, 24'h000001}) begin
            n_fail++;
            $display("FAIL tick_bcd: got sec=%b bcd=%h expected sec=0 bcd=000001", sec_pulse, time_bcd);
        end
    endtask

    task automatic test_rollover();
        load(23, 59, 58);
        step();
        set_valid = 1'b0;
        n_assert++;
        if ({set_ack, hh, mm, ss} !== {1'b1, hms(23, 59, 58)}) begin
            n_fail++;
            $display("FAIL roll_set: got ack=%b %0d:%0d:%0d expected ack=1 23:59:58", set_ack, hh, mm, ss);
        end
        step();
        n_assert++;
        if (time_bcd !== 24'h235958) begin
            n_fail++;
            $display("FAIL roll_bcd_set: got %h expected 235958", time_bcd);
        end
        send_tick();
        n_assert++;
        if ({hh, mm, ss, sec_pulse, min_pulse, day_pulse} !== {hms(23, 59, 59), 3'b100}) begin
            n_fail++;
            $display("FAIL roll_tick1: got %0d:%0d:%0d pulses=%b expected 23:59:59 pulses=100",
                     hh, mm, ss, {sec_pulse, min_pulse, day_pulse});
        end
        send_tick();
        n_assert++;
        if ({hh, mm, ss, sec_pulse, min_pulse, day_pulse} !== {17'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL roll_day_wrap: got %0d:%0d:%0d pulses=%b expected 0:0:0 pulses=111",
                     hh, mm, ss, {sec_pulse, min_pulse, day_pulse});
        end
        step();
        n_assert++;
        if ({time_bcd, day_pulse} !== {24'h000000, 1'b0}) begin
            n_fail++;
            $display("FAIL roll_bcd_wrap: got bcd=%h day=%b expected bcd=000000 day=0", time_bcd, day_pulse);
        end
    endtask

    task automatic test_set();
        load(24, 10, 0);
        step();
        n_assert++;
        if ({set_ack, set_err, hh, mm, ss} !== {2'b01, 17'd0}) begin
            n_fail++;
            $display("FAIL set_err: got ack/err=%b%b %0d:%0d:%0d expected 01 0:0:0",
                     set_ack, set_err, hh, mm, ss);
        end
        load(12, 34, 56);
        step();
        set_valid = 1'b0;
        n_assert++;
        if ({set_ack, set_err, hh, mm, ss} !== {2'b10, hms(12, 34, 56)}) begin
            n_fail++;
            $display("FAIL set_ack: got ack/err=%b%b %0d:%0d:%0d expected 10 12:34:56",
                     set_ack, set_err, hh, mm, ss);
        end
        step();
        n_assert++;
        if ({set_ack, set_err, time_bcd} !== {2'b00, 24'h123456}) begin
            n_fail++;
            $display("FAIL set_bcd: got ack/err=%b%b bcd=%h expected 00 123456", set_ack, set_err, time_bcd);
        end
    endtask

    task automatic test_set_tick_collision();
        clk_1hz = 1'b1;
        step();
        clk_1hz = 1'b0;
        step();
        load(5, 0, 0);
        step();
        set_valid = 1'b0;
        n_assert++;
        if ({hh, mm, ss, set_ack, sec_pulse} !== {hms(5, 0, 0), 2'b10}) begin
            n_fail++;
            $display("FAIL collision: got %0d:%0d:%0d ack=%b sec=%b expected 5:0:0 ack=1 sec=0",
                     hh, mm, ss, set_ack, sec_pulse);
        end
        step();
        n_assert++;
        if ({hh, mm, ss, sec_pulse} !== {hms(5, 0, 0), 1'b0}) begin
            n_fail++;
            $display("FAIL collision_after: got %0d:%0d:%0d sec=%b expected 5:0:0 sec=0",
                     hh, mm, ss, sec_pulse);
        end
    endtask

    task automatic test_run_off();
        run = 1'b0;
        send_tick();
        n_assert++;
        if ({hh, mm, ss, sec_pulse} !== {hms(5, 0, 0), 1'b0}) begin
            n_fail++;
            $display("FAIL run_off: got %0d:%0d:%0d sec=%b expected 5:0:0 sec=0", hh, mm, ss, sec_pulse);
        end
        run = 1'b1;
        repeat (3) step();
        n_assert++;
        if ({ss, sec_pulse} !== 7'd0) begin
            n_fail++;
            $display("FAIL run_off_lost: got ss=%0d sec=%b expected ss=0 sec=0", ss, sec_pulse);
        end
    endtask

    task automatic test_reset_mid();
        load(10, 20, 30);
        step();
        set_valid = 1'b0;
        clk_1hz = 1'b1;
        step();
        clk_1hz = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_assert++;
        if ({hh, mm, ss, time_bcd, sec_pulse, min_pulse, day_pulse, set_ack, set_err} !== 46'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %0d:%0d:%0d bcd=%h pulses=%b expected all zero",
                     hh, mm, ss, time_bcd, {sec_pulse, min_pulse, day_pulse, set_ack, set_err});
        end
        step();
        n_assert++;
        if ({ss, sec_pulse, time_bcd} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got ss=%0d sec=%b bcd=%h expected 0 0 000000",
                     ss, sec_pulse, time_bcd);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) clk_1hz = ~clk_1hz;
            run   = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 399) != 0);
            set_valid = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1) == 0) begin
                set_hh = 5'($urandom_range(HOURS_MAX - 1, 27));
                set_mm = 6'($urandom_range(58, 60));
                set_ss = 6'($urandom_range(50, 60));
            end else begin
                set_hh = 5'($urandom_range(0, 31));
                set_mm = 6'($urandom_range(0, 63));
                set_ss = 6'($urandom_range(0, 63));
            end
            step();
            n_assert++;
            if ({hh, mm, ss} !== hms_of(m_t)) begin
                n_fail++;
                $display("FAIL rand_time cycle %0d: got %0d:%0d:%0d expected %0d:%0d:%0d",
                         c, hh, mm, ss, m_t / 3600, (m_t / 60) % 60, m_t % 60);
            end
            n_assert++;
            if (time_bcd !== m_bcd) begin
                n_fail++;
                $display("FAIL rand_bcd cycle %0d: got %h expected %h", c, time_bcd, m_bcd);
            end
            n_assert++;
            if ({set_ack, set_err, sec_pulse, min_pulse, day_pulse} !== {m_ack, m_err, m_sec, m_min, m_day}) begin
                n_fail++;
                $display("FAIL rand_pulses cycle %0d: got %b expected %b", c,
                         {set_ack, set_err, sec_pulse, min_pulse, day_pulse},
                         {m_ack, m_err, m_sec, m_min, m_day});
            end
        end
        rst_n = 1'b1;
        set_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_rollover();
        test_set();
        test_set_tick_collision();
        test_run_off();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_time_counter.md
Name: tick_time_counter

Overview:
- Consumer end of the 1 Hz divider output.
- Samples the slow square wave `clk_1hz` in the `clk` domain and detects its rising edges, one per second.
- Advances a 24-hour HH:MM:SS time-of-day counter on each detected edge.
- Provides a validated time-set handshake and presents the time in binary and packed BCD for the display and alarm-compare logic.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising `clk_1hz` before edge detection; legal range 1..3.
- HOURS_MAX, 23, last hour value before the hours counter wraps to 0.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous active-low reset.
- clk_1hz  in  1  slow square wave from the divider; each rising edge counts as one second.
- run  in  1  when 1, seconds advance on ticks; when 0, ticks are discarded and time holds.
- set_valid  in  1  time-load request.
- set_hh  in  5  binary hours to load.
- set_mm  in  6  binary minutes to load.
- set_ss  in  6  binary seconds to load.
- set_ack  out  1  1-cycle pulse: set request accepted.
- set_err  out  1  1-cycle pulse: set request rejected as out of range.
- hh  out  5  current hours, binary.
- mm  out  6  current minutes, binary.
- ss  out  6  current seconds, binary.
- time_bcd  out  24  packed BCD {H tens, H units, M tens, M units, S tens, S units}, 4 bits each.
- sec_pulse  out  1  1-cycle pulse when seconds advanced.
- min_pulse  out  1  1-cycle pulse when minutes advanced due to a seconds rollover.
- day_pulse  out  1  1-cycle pulse on the HOURS_MAX:59:59 -> 00:00:00 wrap.

Behaviour:
- Clocking and reset
  - Single clock `clk`; all state updates on posedge `clk`.
  - Reset is synchronous and active-low: while `rst_n` = 0 at a posedge, the following hold:
    - `hh`, `mm`, `ss` = 0; `time_bcd` = 24'h000000.
    - All pulse outputs = 0.
    - The synchroniser chain and the previous-sample flop load the current `clk_1hz` value. A high `clk_1hz` at reset release therefore produces no spurious tick.
- Edge detection
  - tick = (last synchroniser stage == 1) AND (previous sample == 0).
  - If `clk_1hz` is first sampled high at posedge N, tick is asserted during the cycle after posedge N+SYNC_STAGES-1. The counters and `sec_pulse` update at posedge N+SYNC_STAGES.
  - A `clk_1hz` high level held for any duration yields exactly one tick.
- Counting, applied when tick=1, run=1, and no set request this cycle:
  - `ss` < 59: `ss`+1.
  - `ss` == 59: `ss` = 0 and `mm` increments (`min_pulse`=1).
  - `mm` == 59 in that case: `mm` = 0 and `hh` increments.
  - `hh` == HOURS_MAX in that case: `hh` = 0 and `day_pulse`=1.
  - `sec_pulse`=1 on every applied tick. `min_pulse` and `day_pulse` coincide with `sec_pulse`.
  - tick with run=0: no change, no pulses, tick lost (not queued).
- Set handshake
  - Sampled on any cycle with `set_valid`=1. Checked regardless of `run`.
  - Valid when `set_hh` <= HOURS_MAX, `set_mm` <= 59 and `set_ss` <= 59. Then `hh`/`mm`/`ss` load at the next posedge and `set_ack`=1 for that one cycle.
  - Otherwise the time is unchanged and `set_err`=1 for one cycle.
  - `set_valid` held high for k cycles is processed k times: one ack or err per cycle. There is no ready/back-pressure.
  - Set and tick in the same cycle: set wins. The tick is discarded and no second/minute/day pulse is generated.
- BCD output
  - `time_bcd` is registered and tracks `hh`/`mm`/`ss` with 1 cycle latency: it reflects the value committed at the previous posedge.
  - Each digit is in 0..9; tens digits are hours 0..2, minutes/seconds 0..5.
  - Conversion is by constant compare/subtract, no division operators.
- Reset mid-operation: reset wins over set and tick in the same cycle. All outputs return to their reset values at that posedge.

Test Plan:
- Reset with `clk_1hz`=1, then release and hold `clk_1hz` high for 10 cycles -> `ss` stays 0, `sec_pulse` never asserts.
- Default params, run=1, `clk_1hz` 0->1 first sampled at posedge N -> `ss`=1 and `sec_pulse`=1 after posedge N+2; `time_bcd`=24'h000001 one cycle later.
- Set 23:59:58, then apply two ticks -> 23:59:59, then 00:00:00. The second tick gives `sec_pulse`, `min_pulse` and `day_pulse` all =1 in the same cycle; `time_bcd`=24'h000000.
- `set_valid` with hh=24, mm=10, ss=0 -> `set_err` pulse, time unchanged. Then hh=12, mm=34, ss=56 -> `set_ack` pulse, `time_bcd`=24'h123456.
- Tick coincident with a valid set of 05:00:00 -> time=05:00:00, `sec_pulse`=0. A tick with run=0 -> no change and no pulse.
- Assert `rst_n`=0 for one cycle while at 10:20:30 with a tick pending -> all outputs 0 next cycle, no pulse.
